fixed_mean_square: RTL and testbench
====================================

# fixed_mean_square

Streaming mean-of-squares reducer that sits directly upstream of `fixed_isqrt` in the RMS/layer-norm datapath. It accepts a vector of signed fixed-point elements over `DEPTH` beats of `PARALLELISM` lanes, squares and sums them, and divides by the element count. It emits one unsigned `2*IN_WIDTH`-bit mean-square word per vector on a valid/ready handshake, in the exact format `fixed_isqrt.in_data` consumes.

## Interface
- `IN_WIDTH`, 16: element width, signed two's complement.
- `IN_FRAC_WIDTH`, 7: element fractional bits. The output has `2*IN_FRAC_WIDTH` fractional bits.
- `PARALLELISM`, 4: lanes per beat, power of two, ≥1.
- `DEPTH`, 8: beats per vector, power of two, ≥1.
- localparam `N = PARALLELISM*DEPTH`, `LOG_N = $clog2(N)`, `ACC_WIDTH = 2*IN_WIDTH + LOG_N`, `CNT_WIDTH = max(1,$clog2(DEPTH))`.
- `clk`  in  1  clock. One clock domain only; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_data`  in  `PARALLELISM*IN_WIDTH`  packed lanes; lane i is `[i*IN_WIDTH +: IN_WIDTH]`.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`.
- `out_data`  out  `2*IN_WIDTH`  unsigned mean square.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.

## Operation
- Per beat: square each lane signed×signed into `2*IN_WIDTH` bits (always ≥0). Sum the lanes to `ACC_WIDTH` bits and add the sum into `acc`.
- `beat_cnt` counts accepted beats, 0..DEPTH-1, and wraps to 0 on the last beat.
- First beat (`beat_cnt==0`): `acc` loads the beat sum and does not add to the old value. No separate clear cycle is needed.
- Last beat (`beat_cnt==DEPTH-1`) accepted:
  - the output register loads `(acc + beat_sum) >> LOG_N`, truncated (floor);
  - `out_valid` is set.
- Width rule: the mean is ≤ `2^(2*IN_WIDTH-2)`, so it always fits in `2*IN_WIDTH` bits. No saturation logic is needed; the bench asserts this.
- Output register states: EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - FULL→EMPTY on an out handshake with no simultaneous last-beat load.
  - A simultaneous handshake and last-beat load keeps the state FULL with the new data.
- Accumulation of the next vector proceeds while the output is FULL.
- `in_ready = !(beat_cnt==DEPTH-1 && out_valid && !out_ready)`. Only the final beat stalls, and only on a blocked output.
- The `out_ready` → `in_ready` path is combinational.
- Zero vector → `out_data = 0`. Downstream `fixed_isqrt` saturates that case.
- Reset (`rst=0`), asynchronous:
  - `beat_cnt=0`, `acc=0`, `out_data=0`, `out_valid=0`;
  - `in_ready` is then 1;
  - a partial vector in progress is discarded.

## Timing
- Latency: last beat accepted at edge t → `out_valid=1` with the result after edge t. It is visible in cycle t+1.
- Throughput: one beat per cycle sustained, including back-to-back vectors with `out_ready=1`. There are no bubbles between vectors.
- `out_data` is stable while `out_valid & !out_ready` (AXI-style hold rule).
- Squaring and the lane adder tree are combinational within one cycle. The critical path is multiply + `log2(PARALLELISM)` adds + accumulate.
- `DEPTH==1`: every beat is a last beat, and `beat_cnt` stays at 0.

## Structure
- Package `fixed_mean_square_pkg`: `ACC_WIDTH`/`LOG_N` helper functions and the output-state enum (`MS_EMPTY`, `MS_FULL`).
- One sub-module, `fixed_square_sum`: combinational. `PARALLELISM` signed lanes in → sum of squares out, `2*IN_WIDTH + $clog2(PARALLELISM)` bits wide.
- The top level holds the counter, accumulator, output register and handshake. Expected size is 150–250 lines total.

## Test plan
Configuration for all scenarios: `IN_WIDTH=8, IN_FRAC_WIDTH=4, PARALLELISM=4, DEPTH=2` (N=8).
- Unity: 2 beats, all lanes `8'h10` (1.0) → one output `16'h0100` (1.0 in Q8.8), `out_valid` one cycle after the second beat.
- Extreme negative: all lanes `8'h80` (-8.0) → `16'h4000`. No overflow occurs; the output MSB is 0.
- Truncation and zero: lane0 `8'h01`, all others 0 → `16'h0000`. An all-zero vector → `16'h0000`.
- Backpressure: hold `out_ready=0` and stream vectors A (all `8'h10`) and B (all `8'h20`).
  - `in_ready` drops only on B's second beat.
  - Raise `out_ready`: A=`16'h0100` first, then B=`16'h0400`.
  - No loss or duplication.
- Reset mid-vector: accept 1 beat of `8'h7F`, pulse `rst=0` asynchronously (mid-cycle), release, then send a full `8'h10` vector → `16'h0100`. Outputs read 0 and `out_valid=0` while in reset.
- Throughput: 64 random back-to-back vectors with `out_ready=1` → `in_valid` never stalls and outputs match the reference model in order.

Source files
------------

// File: rtl/fixed_mean_square_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fixed_mean_square_pkg
// Description : Shared widths and output-register state for the mean-square
//               reducer.
// Revision    : 1.0 - initial release
// ============================================================================
package fixed_mean_square_pkg;

    typedef enum logic [0:0] {
        MS_EMPTY = 1'b0,
        MS_FULL  = 1'b1
    } ms_state_t;

    function automatic int calc_log_n(input int par, input int depth);
        return $clog2(par * depth);
    endfunction

    function automatic int calc_acc_width(input int in_width, input int par, input int depth);
        return 2 * in_width + calc_log_n(par, depth);
    endfunction

    function automatic int calc_cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_mean_square_square_sum.sv
`default_nettype none
// ============================================================================
// Module      : fixed_square_sum
// Description : Combinational sum of squares across PARALLELISM signed lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_square_sum #(
    parameter int  IN_WIDTH    = 16,
    parameter int  PARALLELISM = 4,
    localparam int SUM_WIDTH   = 2 * IN_WIDTH + $clog2(PARALLELISM)
) (
    input  logic [PARALLELISM*IN_WIDTH-1:0] in_data,
    output logic [SUM_WIDTH-1:0]            sum
);

    logic [2*IN_WIDTH-1:0] w_sq [PARALLELISM];
    logic [SUM_WIDTH-1:0]  w_sum;

    generate
        for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
            logic signed [IN_WIDTH-1:0]   w_lane;
            logic signed [2*IN_WIDTH-1:0] w_ext;
            logic signed [2*IN_WIDTH-1:0] w_prod;
            assign w_lane  = in_data[i*IN_WIDTH +: IN_WIDTH];
            assign w_ext   = {{IN_WIDTH{w_lane[IN_WIDTH-1]}}, w_lane};
            // A square is never negative, so the product is reinterpreted as unsigned.
            assign w_prod  = w_ext * w_ext;
            assign w_sq[i] = w_prod;
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            w_sum = w_sum + SUM_WIDTH'(w_sq[i]);
        end
    end

    assign sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/fixed_mean_square.sv
`default_nettype none
// ============================================================================
// Module      : fixed_mean_square
// Description : Streaming mean of squares over DEPTH beats of PARALLELISM lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_mean_square
    import fixed_mean_square_pkg::*;
#(
    parameter int IN_WIDTH      = 16,
    parameter int IN_FRAC_WIDTH = 7,
    parameter int PARALLELISM   = 4,
    parameter int DEPTH         = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PARALLELISM*IN_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [2*IN_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int LOG_N     = calc_log_n(PARALLELISM, DEPTH);
    localparam int ACC_WIDTH = calc_acc_width(IN_WIDTH, PARALLELISM, DEPTH);
    localparam int CNT_WIDTH = calc_cnt_width(DEPTH);
    localparam int SUM_WIDTH = 2 * IN_WIDTH + $clog2(PARALLELISM);

    generate
        if ((PARALLELISM < 1) || ((PARALLELISM & (PARALLELISM - 1)) != 0)) begin : g_bad_par
            $error("PARALLELISM must be a power of two");
        end
        if ((DEPTH < 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH must be a power of two");
        end
        if ((IN_FRAC_WIDTH < 0) || (IN_FRAC_WIDTH > IN_WIDTH)) begin : g_bad_frac
            $error("IN_FRAC_WIDTH out of range");
        end
    endgenerate

    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [2*IN_WIDTH-1:0] r_out_data;
    ms_state_t             r_state;
    ms_state_t             w_state_next;
    logic [SUM_WIDTH-1:0]  w_beat_sum;
    logic [ACC_WIDTH-1:0]  w_total;
    logic                  w_first;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_load;

    fixed_square_sum #(
        .IN_WIDTH    (IN_WIDTH),
        .PARALLELISM (PARALLELISM)
    ) u_square_sum (
        .in_data (in_data),
        .sum     (w_beat_sum)
    );

    assign w_first  = (r_beat_cnt == '0);
    assign w_last   = (r_beat_cnt == CNT_WIDTH'(DEPTH - 1));
    // First beat restarts the sum, so no clear cycle is needed between vectors.
    assign w_total  = (w_first ? '0 : r_acc) + ACC_WIDTH'(w_beat_sum);
    assign in_ready = !(w_last && out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_state    <= MS_EMPTY;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc      <= w_total;
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_WIDTH'(1);
            end
            // Mean is bounded by 2^(2*IN_WIDTH-2), so the top slice never overflows.
            if (w_load) begin
                r_out_data <= w_total[LOG_N +: 2*IN_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MS_EMPTY: if (w_load) w_state_next = MS_FULL;
            MS_FULL: begin
                if (w_load)         w_state_next = MS_FULL;
                else if (out_ready) w_state_next = MS_EMPTY;
            end
            default:  w_state_next = MS_EMPTY;
        endcase
    end

    assign out_valid = (r_state == MS_FULL);
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fixed_mean_square.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_mean_square
// Description : Directed and random self-checking bench for fixed_mean_square.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_mean_square;

    localparam int IN_WIDTH = 8;
    localparam int PAR      = 4;
    localparam int DEPTH    = 2;

    logic                    clk;
    logic                    rst;
    logic [PAR*IN_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [2*IN_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_q[$];

    fixed_mean_square #(
        .IN_WIDTH      (IN_WIDTH),
        .IN_FRAC_WIDTH (4),
        .PARALLELISM   (PAR),
        .DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rep(input logic [7:0] b);
        return {4{b}};
    endfunction

    function automatic logic [15:0] model_mean(input logic [31:0] b0, input logic [31:0] b1);
        logic [63:0] v;
        int s;
        int e;
        v = {b1, b0};
        s = 0;
        for (int i = 0; i < 8; i++) begin
            e = $signed(v[i*8 +: 8]);
            s += e * e;
        end
        return 16'(s >>> 3);
    endfunction

    // Called right after a posedge (+1); returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [31:0] d);
        int guard;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Output monitor: scoreboard order, range bound and hold-while-blocked rule.
    initial begin
        logic        prev_blocked;
        logic [15:0] prev_data;
        prev_blocked = 1'b0;
        prev_data    = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_blocked = 1'b0;
            end else begin
                if (prev_blocked) check("hold", 32'(out_data), 32'(prev_data));
                if (out_valid && out_ready) begin
                    check("range", 32'(out_data <= 16'h4000), 32'd1);
                    if (exp_q.size() == 0) check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                    else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                prev_blocked = out_valid && !out_ready;
                prev_data    = out_data;
            end
        end
    end

    initial begin
        int stalls;
        logic [31:0] b0;
        logic [31:0] b1;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Unity: 1.0^2 -> 1.0 in Q8.8
        out_ready = 1'b1;
        exp_q.push_back(16'h0100);
        send_beat(rep(8'h10));
        send_beat(rep(8'h10));
        check("unity_latency", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("unity_drain", 32'(out_valid), 32'd0);

        // Extreme negative: (-8)^2 = 64 -> 0x4000
        exp_q.push_back(16'h4000);
        send_beat(rep(8'h80));
        send_beat(rep(8'h80));
        check("extreme_msb", 32'(out_data[15]), 32'd0);

        // Truncation: 1/256 * 1/8 floors to 0; all-zero vector gives 0
        exp_q.push_back(16'h0000);
        send_beat(32'h0000_0001);
        send_beat(32'h0000_0000);
        exp_q.push_back(16'h0000);
        send_beat(32'h0000_0000);
        send_beat(32'h0000_0000);
        repeat (2) @(posedge clk); #1;

        // Backpressure: A then B with the output blocked
        out_ready = 1'b0;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0400);
        check("bp_ready_a0", 32'(in_ready), 32'd1);
        send_beat(rep(8'h10));
        check("bp_ready_a1", 32'(in_ready), 32'd1);
        send_beat(rep(8'h10));
        check("bp_ready_b0", 32'(in_ready), 32'd1);
        send_beat(rep(8'h20));
        in_data  = rep(8'h20);
        in_valid = 1'b1;
        #1;
        check("bp_stall", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("bp_stall_hold", 32'(in_ready), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'h0100);
        out_ready = 1'b1;
        #1;
        check("bp_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_idle", 32'(out_valid), 32'd0);

        // Reset mid-vector discards the partial sum
        send_beat(rep(8'h7F));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(16'h0100);
        send_beat(rep(8'h10));
        send_beat(rep(8'h10));
        repeat (2) @(posedge clk); #1;
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);

        // Throughput: 64 random vectors back to back
        stalls = 0;
        for (int v = 0; v < 64; v++) begin
            b0 = $urandom;
            b1 = $urandom;
            exp_q.push_back(model_mean(b0, b1));
            in_data  = b0;
            in_valid = 1'b1;
            #1;
            if (!in_ready) stalls++;
            @(posedge clk); #1;
            in_data = b1;
            #1;
            if (!in_ready) stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("tput_stalls", 32'(stalls), 32'd0);
        check("tput_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
